phy_tx_stripe_ser: RTL
======================

Name: phy_tx_stripe_ser

Overview:
Parametrised PHY transmit core that generalises the two-lane TX path to N lanes.
- Accepts DATA_W-bit words through a valid/ready handshake into a DEPTH-word input FIFO.
- Stripes the bytes of each word across LANES serial lanes and shifts each lane out MSB-first, one bit per clock.
- Inserts the IDLE_SYM K-symbol whenever no data is available or the link is inactive.
- Sits between the link-layer word source and the lane pads/analog front end, all in the serial clock domain.

Parameters:
- DATA_W, 32, input word width; must be a multiple of 8*LANES.
- LANES, 2, number of serial lanes.
- DEPTH, 4, input FIFO depth in words; power of 2, minimum 2.
- IDLE_SYM, 8'hBC, idle/K symbol sent on empty or inactive.

Ports:
- clk_32f  in  1  serial bit clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- active  in  1  link enable; 0 = accept nothing, send idle after the current word.
- valid  in  1  data_input qualifier.
- data_input  in  DATA_W  word to transmit; byte 0 = bits [DATA_W-1:DATA_W-8].
- ready  out  1  FIFO can accept; push occurs when valid && ready at a clk_32f edge.
- data_out  out  LANES  serial bit per lane (registered).
- is_k  out  LANES  high for all 8 bits of an IDLE_SYM symbol on that lane.
- sym_start  out  1  high during bit 0 (the MSB) of every symbol, common to all lanes.
- fifo_count  out  $clog2(DEPTH)+1  words currently stored.

Behaviour:
Derived constants:
- SPW = DATA_W/(8*LANES), symbols per word per lane.
- Byte k of a word goes to lane k mod LANES, symbol slot k div LANES.
- Lane L in slot s sends data_input byte s*LANES+L.

Reset (synchronous, active-high):
- FIFO empty, fifo_count=0.
- bit_cnt=0, no current word.
- Every lane shift register = IDLE_SYM; data_out = {LANES{IDLE_SYM[7]}} (all 1 for 8'hBC).
- is_k all 1, sym_start=1, ready=0 while reset is high.
- Reset asserted mid-word discards the current word and all FIFO contents; no partial symbol completes.

Bit counter and serialisation:
- bit_cnt counts 0..7 continuously, wrapping after 7, independent of data.
- data_out[L] = shift_reg[L][7]; the shift register shifts left each clock.
- At the edge where bit_cnt==7, each lane loads its next symbol (symbol boundary).
- sym_start = (bit_cnt==0).

Next-symbol selection at a boundary (one decision, shared by all lanes):
- Current word has slots remaining (slot < SPW-1): load slot+1, is_k=0.
- Otherwise, if active==1 and FIFO is non-empty: pop the FIFO head, load slot 0, is_k=0.
- Otherwise: load IDLE_SYM on every lane, is_k=1, current word cleared.
- A word, once started, always completes all SPW slots even if active drops; a word is never truncated.

Handshake and FIFO:
- ready = active && !full && !reset.
- When full, ready=0 even if a pop happens in the same cycle; no push-through.
- Push and pop in the same cycle (non-full, non-empty): fifo_count unchanged, ordering preserved.
- Pop from an empty FIFO never occurs.
- FIFO pointers wrap modulo DEPTH.
- fifo_count is registered and reflects pushes/pops of the previous edge.

Latency and throughput:
- A word pushed into an empty FIFO while lanes are idle has its first data bit on data_out between 1 and 8 cycles after the push edge, at the next symbol boundary.
- Sustained throughput: one word per SPW*8 clocks; back-to-back words have no idle symbol between them.

active low:
- With active=0, FIFO contents are retained but not drained.
- Draining resumes at the first boundary after active returns to 1.

Test Plan:
- Reset for 3 cycles, then idle with active=1, no valid -> data_out=2'b11 during reset; each lane repeats 10111100 aligned to sym_start; is_k=2'b11; fifo_count=0.
- Push 32'h3FE115E6 (defaults) -> lane0 sends 0x3F then 0x15, lane1 sends 0xE1 then 0xE6, MSB-first; is_k=0 for those 16 cycles, then idle resumes with is_k=1.
- Push 32'hFFFFEEEE, 32'hFFEEEEEE, 32'hCCEEEEEE back-to-back -> 48 contiguous data cycles with no idle between words; lane1 symbol sequence FF,EE,EE,EE,EE,EE.
- Hold valid=1 with 6 distinct words while lanes drain -> ready falls when fifo_count=4; no word is lost or duplicated; output order equals input order.
- Drop active to 0 at bit 3 of slot 0 of word 32'hAAAA1234 -> slot 1 (lane0 0x12, lane1 0x34) still completes, then idle; a queued 32'h12345678 is not sent until active=1, then starts at the next boundary.
- Assert reset at bit 5 of a data symbol with fifo_count=2 -> the next edge gives data_out=2'b11, fifo_count=0, is_k=2'b11; no further data symbols are sent.

Source files
------------

// File: rtl/phy_tx_stripe_ser.sv
// Purpose: N-lane PHY transmit core. Words enter a FIFO and their bytes are striped
//          across the lanes, then each lane is shifted out MSB-first, one bit per clock.
// Latency: a word pushed while the lanes are idle starts 1..8 clocks later, at the next symbol boundary.
// Backpressure: ready drops when the FIFO is full, when active is low, or while reset is high.
//
// Ports:
//   clk_32f     serial bit clock (the only clock)
//   reset       synchronous, active-high reset
//   active      link enable; low = accept nothing, go idle once the current word completes
//   valid/ready word push handshake; data_input byte 0 is the top byte
//   data_out    one serial bit per lane, taken from the lane shift registers
//   is_k        per lane, high for all 8 bits of an IDLE_SYM symbol
//   sym_start   high during the MSB of every symbol (common to all lanes)
//   fifo_count  words currently held in the input FIFO
module phy_tx_stripe_ser #(
    parameter int         DATA_W   = 32,
    parameter int         LANES    = 2,
    parameter int         DEPTH    = 4,
    parameter logic [7:0] IDLE_SYM = 8'hBC
) (
    input  logic                   clk_32f,
    input  logic                   reset,
    input  logic                   active,
    input  logic                   valid,
    input  logic [DATA_W-1:0]      data_input,
    output logic                   ready,
    output logic [LANES-1:0]       data_out,
    output logic [LANES-1:0]       is_k,
    output logic                   sym_start,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int SPW    = DATA_W / (8 * LANES);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int SLOT_W = (SPW > 1) ? $clog2(SPW) : 1;

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    // Serialiser state
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_shift [LANES];
    logic [LANES-1:0]  r_is_k;
    logic [DATA_W-1:0] r_word;
    logic [SLOT_W-1:0] r_slot;
    logic              r_has_word;

    // Combinational next-symbol selection
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_boundary;
    logic              w_cont;
    logic              w_load;
    logic [DATA_W-1:0] w_load_word;
    logic [SLOT_W-1:0] w_load_slot;
    logic [DATA_W-1:0] w_shifted;
    logic [7:0]        w_next_sym [LANES];

    always_comb begin
        w_full      = (r_count == CNT_W'(DEPTH));
        w_empty     = (r_count == '0);
        ready       = active && !w_full && !reset;
        w_push      = valid && ready;
        w_boundary  = (r_bit_cnt == 3'd7);
        // A started word always runs to its last slot, regardless of active.
        w_cont      = r_has_word && (int'(r_slot) < SPW - 1);
        w_pop       = w_boundary && !w_cont && active && !w_empty;
        w_load      = w_cont || w_pop;
        w_load_word = w_cont ? r_word : r_mem[r_rd_ptr];
        w_load_slot = w_cont ? (r_slot + SLOT_W'(1)) : '0;
        w_shifted   = '0;
        for (int l = 0; l < LANES; l++) begin
            // Lane l in slot s carries byte s*LANES+l; byte 0 is the top byte.
            w_shifted     = w_load_word << (8 * (int'(w_load_slot) * LANES + l));
            w_next_sym[l] = w_shifted[DATA_W-1 -: 8];
        end
    end

    // Storage has no reset: validity is tracked entirely by the pointers and count.
    always_ff @(posedge clk_32f) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_input;
        end
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_bit_cnt  <= '0;
            r_is_k     <= '1;
            r_word     <= '0;
            r_slot     <= '0;
            r_has_word <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                r_shift[l] <= IDLE_SYM;
            end
        end else begin
            // Free-running symbol phase, wraps 7 -> 0.
            r_bit_cnt <= r_bit_cnt + 3'd1;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase

            if (w_boundary) begin
                if (w_load) begin
                    r_is_k     <= '0;
                    r_has_word <= 1'b1;
                    r_slot     <= w_load_slot;
                    r_word     <= w_load_word;
                    for (int l = 0; l < LANES; l++) begin
                        r_shift[l] <= w_next_sym[l];
                    end
                end else begin
                    r_is_k     <= '1;
                    r_has_word <= 1'b0;
                    r_slot     <= '0;
                    for (int l = 0; l < LANES; l++) begin
                        r_shift[l] <= IDLE_SYM;
                    end
                end
            end else begin
                for (int l = 0; l < LANES; l++) begin
                    r_shift[l] <= {r_shift[l][6:0], 1'b0};
                end
            end
        end
    end

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            data_out[l] = r_shift[l][7];
        end
        is_k       = r_is_k;
        sym_start  = (r_bit_cnt == 3'd0);
        fifo_count = r_count;
    end

endmodule
